// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types for the message padding stage.
package sha256_pkg;
  localparam int         SHA256_BLK_W    = 512;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;
  localparam int         SHA256_LEN_OFS  = 56;
  localparam int         SHA256_BYTES    = 64;

  typedef enum logic {FILL, EMIT} state_e;
  typedef logic [SHA256_BLK_W-1:0] blk_t;
endpackage

// File: rtl/sha256_pad_tail.sv
// Combinational pad builder: 0x80/length overlay for the current block and the extra tail block.
// Zero latency; no handshake of its own.
module sha256_pad_tail
  import sha256_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [5:0]       p,
  input  logic             mark,
  input  logic [LEN_W-1:0] len,
  output blk_t             pad_ovl,
  output blk_t             tail_blk
);
  logic [63:0] len_bits;

  always_comb begin
    len_bits = 64'({len, 3'b000});

    // 0x80 lands right after the final data byte; length only fits when that byte is below 55
    pad_ovl = '0;
    for (int k = 1; k < SHA256_BYTES; k++)
      if (p == 6'(k - 1)) pad_ovl[SHA256_BLK_W-1-8*k -: 8] = SHA256_PAD_BYTE;
    if (p < 6'(SHA256_LEN_OFS - 1)) pad_ovl[63:0] = len_bits;

    tail_blk = '0;
    tail_blk[SHA256_BLK_W-1 -: 8] = mark ? SHA256_PAD_BYTE : 8'h00;
    tail_blk[63:0] = len_bits;
  end
endmodule

// File: rtl/sha256_msg_pad.sv
// Packs a byte stream into FIPS 180-4 padded 512-bit blocks; block valid one cycle after the 64th/last byte.
// Input stalls (i_ready=0) whenever a block is pending; the block is held stable until o_ready.
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [7:0]              i_data,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [SHA256_BLK_W-1:0] o_block,
  output logic                    o_first,
  output logic                    o_last,
  output logic                    o_err
);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e           state, state_nxt;
  logic [5:0]       ptr, ptr_nxt;
  logic [LEN_W-1:0] len, len_nxt, len_inc, len_sel;
  blk_t             blk_q, blk_nxt, blk_wr, pad_ovl, tail_blk;
  logic             first, first_nxt;
  logic             last_q, last_nxt;
  logic             tail, tail_nxt;
  logic             mark, mark_nxt;
  logic             err, err_nxt;

  assign len_inc = (len == LEN_MAX) ? len : len + 1'b1;
  // In FILL the overlay must carry the count including the byte being accepted
  assign len_sel = (state == FILL) ? len_inc : len;

  sha256_pad_tail #(.LEN_W(LEN_W)) u_tail (
    .p        (ptr),
    .mark     (mark),
    .len      (len_sel),
    .pad_ovl  (pad_ovl),
    .tail_blk (tail_blk)
  );

  always_comb begin
    blk_wr = blk_q;
    for (int k = 0; k < SHA256_BYTES; k++)
      if (ptr == 6'(k)) blk_wr[SHA256_BLK_W-1-8*k -: 8] = i_data;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    len_nxt   = len;
    blk_nxt   = blk_q;
    first_nxt = first;
    last_nxt  = last_q;
    tail_nxt  = tail;
    mark_nxt  = mark;
    err_nxt   = err;
    case (state)
      FILL: begin
        if (i_valid) begin
          len_nxt = len_inc;
          if (len == LEN_MAX) err_nxt = 1'b1;
          ptr_nxt = ptr + 1'b1;
          blk_nxt = blk_wr;
          if (i_last) begin
            blk_nxt   = blk_wr | pad_ovl;
            state_nxt = EMIT;
            if (ptr < 6'(SHA256_LEN_OFS - 1)) begin
              last_nxt = 1'b1;
            end else begin
              tail_nxt = 1'b1;
              mark_nxt = (ptr == 6'(SHA256_BYTES - 1));
            end
          end else if (ptr == 6'(SHA256_BYTES - 1)) begin
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (o_ready) begin
          if (last_q) begin
            blk_nxt   = '0;
            ptr_nxt   = '0;
            len_nxt   = '0;
            tail_nxt  = 1'b0;
            last_nxt  = 1'b0;
            first_nxt = 1'b1;
            state_nxt = FILL;
          end else if (tail) begin
            blk_nxt   = tail_blk;
            last_nxt  = 1'b1;
            tail_nxt  = 1'b0;
            first_nxt = 1'b0;
          end else begin
            blk_nxt   = '0;
            ptr_nxt   = '0;
            first_nxt = 1'b0;
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      ptr    <= '0;
      len    <= '0;
      blk_q  <= '0;
      first  <= 1'b1;
      last_q <= 1'b0;
      tail   <= 1'b0;
      mark   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      len    <= len_nxt;
      blk_q  <= blk_nxt;
      first  <= first_nxt;
      last_q <= last_nxt;
      tail   <= tail_nxt;
      mark   <= mark_nxt;
      err    <= err_nxt;
    end
  end

  assign i_ready = (state == FILL);
  assign o_valid = (state == EMIT);
  assign o_block = blk_q;
  assign o_first = first;
  assign o_last  = last_q;
  assign o_err   = err;
endmodule
